// File: rtl/mips_main_controller_if.sv
// rtl/mips_main_controller_if.sv - opcode/handshake inputs and datapath controls of the main FSM
interface mips_main_controller_if #(
   parameter int STATE_W = 4
);
   logic [5:0]         op;
   logic               mem_ready;
   logic               PCWriteCond;
   logic               PCWrite;
   logic [1:0]         PCSource;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               MemToReg;
   logic               IRWrite;
   logic               RegWrite;
   logic               RegDst;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         ALUOp;
   logic [STATE_W-1:0] state_out;
   logic               illegal_op;
   logic               mem_timeout;

   modport master (
      input  op, mem_ready,
      output PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite, MemToReg,
             IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
             state_out, illegal_op, mem_timeout
   );

   modport slave (
      output op, mem_ready,
      input  PCWriteCond, PCWrite, PCSource, IorD, MemRead, MemWrite, MemToReg,
             IRWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
             state_out, illegal_op, mem_timeout
   );
endinterface

// File: rtl/mips_main_controller.sv
// rtl/mips_main_controller.sv - multicycle MIPS main control FSM with memory-ready stalls
module mips_main_controller #(
   parameter int STATE_W      = 4,
   parameter int MEM_WAIT_MAX = 255
) (
   input  logic                   clk,
   input  logic                   reset,
   mips_main_controller_if.master bus
);
   localparam int CNT_W = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(MEM_WAIT_MAX);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_WAIT_MAX - 1);

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_REXEC  = 4'd6,  S_RWB    = 4'd7,
      S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_q, timeout_d;
   logic             waiting;

   logic       pc_write_cond, pc_write, iord, mem_read, mem_write, mem_to_reg;
   logic       ir_write, reg_write, reg_dst, alu_src_a, illegal;
   logic [1:0] pc_source, alu_src_b, alu_op;

   always_comb begin
      state_d       = S_FETCH;
      pc_write_cond = 1'b0;
      pc_write      = 1'b0;
      pc_source     = 2'b00;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      illegal       = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            // PC and IR only advance on the cycle the fetch completes
            ir_write  = bus.mem_ready;
            pc_write  = bus.mem_ready;
            state_d   = bus.mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (bus.op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_REXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            if (bus.op == OP_LW)      state_d = S_MEMRD;
            else if (bus.op == OP_SW) state_d = S_MEMWR;
            else                      state_d = S_FETCH;
         end
         S_MEMRD: begin
            mem_read  = 1'b1;
            iord      = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = bus.mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEMWR: begin
            mem_write = 1'b1;
            iord      = 1'b1;
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = bus.mem_ready ? S_FETCH : S_MEMWR;
         end
         S_REXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 2'b10;
            state_d   = S_RWB;
         end
         S_RWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = 2'b01;
            pc_write_cond = 1'b1;
            pc_source     = 2'b01;
         end
         S_JUMP: begin
            pc_write  = 1'b1;
            pc_source = 2'b10;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_d   = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write = 1'b1;
         end
         default: state_d = S_FETCH;
      endcase

      // Reset must kill strobes in the same cycle, e.g. a stalled store
      if (!reset) begin
         pc_write_cond = 1'b0;
         pc_write      = 1'b0;
         pc_source     = 2'b00;
         iord          = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         mem_to_reg    = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         reg_dst       = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         illegal       = 1'b0;
      end

      waiting    = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                   && !bus.mem_ready;
      wait_cnt_d = waiting ? ((wait_cnt_q == WAIT_MAX) ? WAIT_MAX : wait_cnt_q + CNT_W'(1))
                           : '0;
      timeout_d  = timeout_q | (waiting && (wait_cnt_q >= WAIT_LAST));
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= S_FETCH;
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign bus.PCWriteCond = pc_write_cond;
   assign bus.PCWrite     = pc_write;
   assign bus.PCSource    = pc_source;
   assign bus.IorD        = iord;
   assign bus.MemRead     = mem_read;
   assign bus.MemWrite    = mem_write;
   assign bus.MemToReg    = mem_to_reg;
   assign bus.IRWrite     = ir_write;
   assign bus.RegWrite    = reg_write;
   assign bus.RegDst      = reg_dst;
   assign bus.ALUSrcA     = alu_src_a;
   assign bus.ALUSrcB     = alu_src_b;
   assign bus.ALUOp       = alu_op;
   assign bus.illegal_op  = illegal;
   assign bus.mem_timeout = timeout_q;
   assign bus.state_out   = STATE_W'(state_q);
endmodule

// File: tb/tb_mips_main_controller.sv
// tb/tb_mips_main_controller.sv - table-driven bench for the multicycle MIPS main controller
module tb_mips_main_controller;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mips_main_controller_if #(.STATE_W(4)) bus ();

   mips_main_controller #(.STATE_W(4), .MEM_WAIT_MAX(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Control word: PCWC PCW PCSrc[2] IorD MR MW M2R IRW RW RDst ASA ASB[2] ALUOp[2] ILL TO
   localparam logic [17:0] F_PCWC     = 18'(1) << 17;
   localparam logic [17:0] F_PCW      = 18'(1) << 16;
   localparam logic [17:0] PCS_ALUOUT = 18'(1) << 14;
   localparam logic [17:0] PCS_JUMP   = 18'(2) << 14;
   localparam logic [17:0] F_IORD     = 18'(1) << 13;
   localparam logic [17:0] F_MR       = 18'(1) << 12;
   localparam logic [17:0] F_MW       = 18'(1) << 11;
   localparam logic [17:0] F_M2R      = 18'(1) << 10;
   localparam logic [17:0] F_IRW      = 18'(1) << 9;
   localparam logic [17:0] F_RW       = 18'(1) << 8;
   localparam logic [17:0] F_RDST     = 18'(1) << 7;
   localparam logic [17:0] F_ASA      = 18'(1) << 6;
   localparam logic [17:0] ASB_4      = 18'(1) << 4;
   localparam logic [17:0] ASB_IMM    = 18'(2) << 4;
   localparam logic [17:0] ASB_SH     = 18'(3) << 4;
   localparam logic [17:0] AOP_SUB    = 18'(1) << 2;
   localparam logic [17:0] AOP_FN     = 18'(2) << 2;
   localparam logic [17:0] F_ILL      = 18'(2);
   localparam logic [17:0] F_TO       = 18'(1);

   localparam logic [17:0] C_NONE    = 18'(0);
   localparam logic [17:0] C_FETCH_W = F_MR | ASB_4;
   localparam logic [17:0] C_FETCH_R = F_MR | ASB_4 | F_IRW | F_PCW;
   localparam logic [17:0] C_DECODE  = ASB_SH;
   localparam logic [17:0] C_ILL     = ASB_SH | F_ILL;
   localparam logic [17:0] C_MEMADR  = F_ASA | ASB_IMM;
   localparam logic [17:0] C_MEMRD   = F_MR | F_IORD | F_ASA | ASB_IMM;
   localparam logic [17:0] C_MEMWB   = F_RW | F_M2R;
   localparam logic [17:0] C_MEMWR   = F_MW | F_IORD | F_ASA | ASB_IMM;
   localparam logic [17:0] C_REXEC   = F_ASA | AOP_FN;
   localparam logic [17:0] C_RWB     = F_RW | F_RDST;
   localparam logic [17:0] C_BRANCH  = F_ASA | AOP_SUB | F_PCWC | PCS_ALUOUT;
   localparam logic [17:0] C_JUMP    = F_PCW | PCS_JUMP;
   localparam logic [17:0] C_ADDIEX  = F_ASA | ASB_IMM;
   localparam logic [17:0] C_ADDIWB  = F_RW;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_BAD  = 6'b111111;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic        rdy;
      logic [3:0]  st;
      logic [17:0] ctl;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic logic [17:0] got_ctl();
      return {bus.PCWriteCond, bus.PCWrite, bus.PCSource, bus.IorD, bus.MemRead,
              bus.MemWrite, bus.MemToReg, bus.IRWrite, bus.RegWrite, bus.RegDst,
              bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal_op, bus.mem_timeout};
   endfunction

   task automatic add(input logic rst, input logic [5:0] op, input logic rdy,
                      input logic [3:0] st, input logic [17:0] ctl);
      vec_t v;
      v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
      vecs.push_back(v);
   endtask

   // One cycle: drive inputs after the falling edge, then compare the cycle's outputs
   task automatic apply(input logic rst, input logic [5:0] op, input logic rdy,
                        input logic [3:0] st, input logic [17:0] ctl, input string name);
      logic [17:0] g;
      @(negedge clk);
      reset         = rst;
      bus.op        = op;
      bus.mem_ready = rdy;
      #1;
      g = got_ctl();
      n_vec++;
      if (bus.state_out !== st || g !== ctl) begin
         n_bad++;
         $display("FAIL %s: state=%0d ctl=%b, expected state=%0d ctl=%b",
                  name, bus.state_out, g, st, ctl);
      end
   endtask

   task automatic check_val(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   initial begin
      reset         = 1'b0;
      bus.op        = OP_R;
      bus.mem_ready = 1'b1;
      repeat (2) @(posedge clk);

      add(1'b0, OP_R,    1'b1, 4'd0,  C_NONE);
      add(1'b1, OP_R,    1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_R,    1'b1, 4'd1,  C_DECODE);
      add(1'b1, OP_R,    1'b1, 4'd6,  C_REXEC);
      add(1'b1, OP_R,    1'b1, 4'd7,  C_RWB);
      add(1'b1, OP_LW,   1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_LW,   1'b1, 4'd1,  C_DECODE);
      add(1'b1, OP_LW,   1'b1, 4'd2,  C_MEMADR);
      add(1'b1, OP_LW,   1'b0, 4'd3,  C_MEMRD);
      add(1'b1, OP_LW,   1'b0, 4'd3,  C_MEMRD);
      add(1'b1, OP_LW,   1'b0, 4'd3,  C_MEMRD);
      add(1'b1, OP_LW,   1'b1, 4'd3,  C_MEMRD);
      add(1'b1, OP_LW,   1'b1, 4'd4,  C_MEMWB);
      add(1'b1, OP_BEQ,  1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_BEQ,  1'b1, 4'd1,  C_DECODE);
      add(1'b1, OP_BEQ,  1'b1, 4'd8,  C_BRANCH);
      add(1'b1, OP_J,    1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_J,    1'b1, 4'd1,  C_DECODE);
      add(1'b1, OP_J,    1'b1, 4'd9,  C_JUMP);
      add(1'b1, OP_ADDI, 1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_ADDI, 1'b1, 4'd1,  C_DECODE);
      add(1'b1, OP_ADDI, 1'b1, 4'd10, C_ADDIEX);
      add(1'b1, OP_ADDI, 1'b1, 4'd11, C_ADDIWB);
      add(1'b1, OP_SW,   1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_SW,   1'b1, 4'd1,  C_DECODE);
      add(1'b1, OP_SW,   1'b1, 4'd2,  C_MEMADR);
      add(1'b1, OP_SW,   1'b1, 4'd5,  C_MEMWR);
      add(1'b1, OP_BAD,  1'b1, 4'd0,  C_FETCH_R);
      add(1'b1, OP_BAD,  1'b1, 4'd1,  C_ILL);
      add(1'b1, OP_R,    1'b1, 4'd0,  C_FETCH_R);

      foreach (vecs[i])
         apply(vecs[i].rst, vecs[i].op, vecs[i].rdy, vecs[i].st, vecs[i].ctl,
               $sformatf("vec%0d", i));

      // Fetch stall past the wait limit: timeout appears after the 4th wait cycle and sticks
      apply(1'b0, OP_R, 1'b0, 4'd1, C_NONE, "to_reset");
      for (int k = 1; k <= 6; k++)
         apply(1'b1, OP_SW, 1'b0, 4'd0, (k >= 5) ? (C_FETCH_W | F_TO) : C_FETCH_W,
               $sformatf("to_wait%0d", k));
      apply(1'b1, OP_SW, 1'b1, 4'd0, C_FETCH_R | F_TO, "to_fetch_done");
      apply(1'b1, OP_SW, 1'b1, 4'd1, C_DECODE  | F_TO, "to_decode");
      apply(1'b1, OP_SW, 1'b1, 4'd2, C_MEMADR  | F_TO, "to_memadr");
      apply(1'b1, OP_SW, 1'b0, 4'd5, C_MEMWR   | F_TO, "memwr_stall1");
      apply(1'b1, OP_SW, 1'b0, 4'd5, C_MEMWR   | F_TO, "memwr_stall2");

      // Reset asserted mid-cycle while a store is stalled
      reset = 1'b0;
      #1;
      check_val("rst_memwrite_drop", 8'(bus.MemWrite), 8'd0);
      check_val("rst_state_held",    8'(bus.state_out), 8'd5);
      @(posedge clk);
      #1;
      check_val("rst_state_fetch",   8'(bus.state_out), 8'd0);
      check_val("rst_timeout_clear", 8'(bus.mem_timeout), 8'd0);
      apply(1'b1, OP_R, 1'b1, 4'd0, C_FETCH_R, "post_reset_fetch");
      apply(1'b1, OP_R, 1'b1, 4'd1, C_DECODE,  "post_reset_decode");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/mips_main_controller.md
Name: mips_main_controller

Overview:
Main control FSM for the multicycle MIPS core. It decodes the 6-bit opcode from the instruction register and drives every datapath control signal: PC write, mux selects, IR/register writes, and the memory read/write strobes. The ALU-function decode block receives a 2-bit ALUOp from this FSM. Memory accesses use a ready handshake so the core tolerates multi-cycle memory.

Parameters:
STATE_W, 4, width of state register
MEM_WAIT_MAX, 255, cycles waited on mem_ready before asserting mem_timeout

Ports:
clk  in  1  core clock, rising edge
reset  in  1  synchronous, active-low reset
op  in  6  opcode from instruction register
mem_ready  in  1  memory has completed the current read/write this cycle
PCWriteCond  out  1  PC write if ALU zero (beq)
PCWrite  out  1  unconditional PC write
PCSource  out  2  next-PC select: 00 ALU result, 01 aluOut, 10 jump target
IorD  out  1  memory address select: 0 PC, 1 aluOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
MemToReg  out  1  register write data: 0 aluOut, 1 memory data register
IRWrite  out  1  load instruction register
RegWrite  out  1  register file write enable
RegDst  out  1  write address: 0 rt, 1 rd
ALUSrcA  out  1  0 PC, 1 register A
ALUSrcB  out  2  00 register B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
ALUOp  out  2  00 add, 01 subtract, 10 use funct
state_out  out  STATE_W  current state, for debug
illegal_op  out  1  one-cycle pulse on unrecognised opcode
mem_timeout  out  1  sticky; set when a memory wait exceeds MEM_WAIT_MAX

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on port reset: reset==0 sampled at a rising edge.
- Reset effects: state<=FETCH(0), wait counter<=0, mem_timeout<=0. While reset==0, all control outputs and illegal_op are forced to 0 combinationally.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12-15 go to FETCH on the next edge with all outputs 0.
- Any output not listed for a state below is 0.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite=PCWrite=mem_ready (Mealy).
  - Transition: to DECODE if mem_ready, else stay in FETCH. PC and IR are unchanged during the stall.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into aluOut).
  - Transitions by op: lw/sw->MEMADR, R->REXEC, beq->BRANCH, j->JUMP, addi->ADDIEX.
  - Other op: ->FETCH with illegal_op=1 for this cycle.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: lw->MEMRD, sw->MEMWR.
- MEMRD:
  - Outputs: MemRead=1, IorD=1. ALUSrcA=1, ALUSrcB=10, ALUOp=00 are held so aluOut stays stable while stalled.
  - Transition: ->MEMWB on mem_ready, else stay.
- MEMWB: RegWrite=1, MemToReg=1, RegDst=0. Next: FETCH.
- MEMWR:
  - Outputs: MemWrite=1, IorD=1, address operands held as in MEMRD.
  - Transition: ->FETCH on mem_ready, else stay. MemWrite stays high for the whole wait.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next: RWB.
- RWB: RegWrite=1, RegDst=1, MemToReg=0. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. Next: FETCH.
- JUMP: PCWrite=1, PCSource=10. Next: FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next: ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemToReg=0. Next: FETCH.
- Latency with mem_ready tied high: R/addi/sw 4 cycles; lw 5; beq/j 3.
- Wait counter:
  - Counts cycles in FETCH/MEMRD/MEMWR with mem_ready=0, and clears on mem_ready=1 or any state change.
  - Saturates at MEM_WAIT_MAX. On reaching it, mem_timeout<=1, sticky until reset.
  - The FSM keeps waiting after timeout; there is no forced abort.
- Reset mid-operation (e.g. in MEMWR while stalled): MemWrite drops to 0 immediately (combinational force) and state is FETCH at the next edge.

Test Plan:
- Reset, then mem_ready=1, op=000000 -> states 0,1,6,7,0. REXEC ALUOp=10. RWB RegWrite=1, RegDst=1. Next FETCH has IRWrite=PCWrite=1.
- op=100011 with mem_ready low for 3 cycles in MEMRD -> states 0,1,2,3,3,3,3,4,0. IorD=1 and MemRead=1 throughout MEMRD. MEMWB MemToReg=1, RegWrite=1.
- op=000100 -> BRANCH has PCWriteCond=1, PCWrite=0, PCSource=01, ALUOp=01. op=000010 -> JUMP has PCWrite=1, PCSource=10.
- op=111111 -> DECODE pulses illegal_op=1 for exactly 1 cycle, next state FETCH, no RegWrite/MemWrite asserted.
- Set MEM_WAIT_MAX=4 and hold mem_ready=0 in FETCH for 6 cycles -> mem_timeout rises after the 4th wait cycle. IRWrite stays 0. mem_timeout stays 1 after mem_ready returns, until reset==0.
- op=101011 in MEMWR stalled, reset driven 0 for one edge -> MemWrite=0 in the same cycle, state_out=0 after the edge, mem_timeout cleared.
